// File: rtl/rv32_mc_pkg.sv
// Shared constants for the RV32I multicycle core: FSM state codes, opcodes and
// the funct3 values that steer branch and store dispatch.
package rv32_mc_pkg;

  localparam int STATE_W = 5;

  localparam logic [4:0] S_FETCH  = 5'd0;
  localparam logic [4:0] S_DECODE = 5'd1;
  localparam logic [4:0] S_MEMADR = 5'd2;
  localparam logic [4:0] S_MEMRD  = 5'd3;
  localparam logic [4:0] S_LDWB   = 5'd4;
  localparam logic [4:0] S_SW     = 5'd5;
  localparam logic [4:0] S_REXE   = 5'd6;
  localparam logic [4:0] S_RWB    = 5'd7;
  localparam logic [4:0] S_BEQ    = 5'd8;
  localparam logic [4:0] S_IEXE   = 5'd9;
  localparam logic [4:0] S_IWB    = 5'd10;
  localparam logic [4:0] S_JAL    = 5'd11;
  localparam logic [4:0] S_JALR   = 5'd12;
  localparam logic [4:0] S_SB     = 5'd13;
  localparam logic [4:0] S_SH     = 5'd14;
  localparam logic [4:0] S_BNE    = 5'd15;
  localparam logic [4:0] S_BLT    = 5'd16;
  localparam logic [4:0] S_BGE    = 5'd17;
  localparam logic [4:0] S_BLTU   = 5'd18;
  localparam logic [4:0] S_BGEU   = 5'd19;
  localparam logic [4:0] S_AUIPC  = 5'd20;
  localparam logic [4:0] S_LUI    = 5'd21;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Final state of a legal instruction: the instruction retires here.
  function automatic logic is_last_state(input logic [4:0] s);
    return (s == S_LDWB) || (s == S_SW) || (s == S_RWB) || (s == S_BEQ) ||
           ((s >= S_IWB) && (s <= S_LUI));
  endfunction

endpackage

// File: rtl/main_fsm_decode_dispatch.sv
// DECODE-state dispatch: maps opcode/funct3 to the first post-decode state and
// flags encodings the core does not implement.
module decode_dispatch
  import rv32_mc_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic [4:0] target,
  output logic       illegal
);

  always_comb begin
    target  = S_FETCH;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        target  = S_MEMADR;
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        target  = S_MEMADR;
        illegal = (funct3 > F3_SW);
      end
      OP_RTYPE: target = S_REXE;
      OP_IALU:  target = S_IEXE;
      OP_JAL:   target = S_JAL;
      OP_JALR:  target = S_JALR;
      OP_AUIPC: target = S_AUIPC;
      OP_LUI:   target = S_LUI;
      OP_BRANCH: begin
        case (funct3)
          F3_BEQ:  target = S_BEQ;
          F3_BNE:  target = S_BNE;
          F3_BLT:  target = S_BLT;
          F3_BGE:  target = S_BGE;
          F3_BLTU: target = S_BLTU;
          F3_BGEU: target = S_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
    // An illegal decode always falls back to FETCH.
    if (illegal) target = S_FETCH;
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle RV32I next-state sequencer: state register, memory-stage fan-out,
// illegal-decode pulse and retired-instruction counter.
module main_fsm
  import rv32_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  output logic [4:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret
);

  logic [4:0]       state_reg;
  logic [4:0]       state_next;
  logic             illegal_reg;
  logic             illegal_next;
  logic [CNT_W-1:0] instret_reg;
  logic [4:0]       dispatch_target;
  logic             dispatch_illegal;

  decode_dispatch u_dispatch (
    .opcode  (opcode),
    .funct3  (funct3),
    .target  (dispatch_target),
    .illegal (dispatch_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      illegal_reg <= 1'b0;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (instr_done) instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next   = S_FETCH;
    illegal_next = 1'b0;
    case (state_reg)
      S_FETCH: state_next = S_DECODE;
      S_DECODE: begin
        state_next   = dispatch_target;
        illegal_next = dispatch_illegal;
      end
      S_MEMADR: begin
        if (opcode == OP_LOAD) begin
          state_next = S_MEMRD;
        end else begin
          case (funct3)
            F3_SB:   state_next = S_SB;
            F3_SH:   state_next = S_SH;
            F3_SW:   state_next = S_SW;
            default: state_next = S_FETCH;
          endcase
        end
      end
      S_MEMRD: state_next = S_LDWB;
      S_REXE:  state_next = S_RWB;
      S_IEXE:  state_next = S_IWB;
      default: begin
        state_next   = S_FETCH;
        // Unreachable codes recover to FETCH and are reported.
        illegal_next = (state_reg > S_LUI);
      end
    endcase
  end

  always_comb begin
    instr_done = is_last_state(state_reg);
  end

  assign state      = state_reg;
  assign illegal_op = illegal_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks legal and illegal instructions through
// the sequencer and compares state, status pulses and the retire counter.
module tb_main_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] state;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] instret;

  int n_checks;
  int n_errors;
  logic [3:0] cnt_model;

  main_fsm #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge with state in FETCH; returns at the
  // same point of the following FETCH. Sequence is 0,1,s2,s3,s4 cut to n states.
  task automatic do_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] s2, input logic [4:0] s3, input logic [4:0] s4,
                          input int n, input bit ill);
    logic [4:0] seq [5];
    seq[0] = 5'd0; seq[1] = 5'd1; seq[2] = s2; seq[3] = s3; seq[4] = s4;
    opcode = op;
    funct3 = f3;
    for (int i = 0; i < n; i++) begin
      check_val({tag, " state"}, {27'd0, state}, {27'd0, seq[i]});
      check_val({tag, " instr_done"}, {31'd0, instr_done}, {31'd0, (i == n - 1) && !ill});
      if (i == 1) check_val({tag, " illegal_op width"}, {31'd0, illegal_op}, 32'd0);
      @(posedge clk); #1;
    end
    if (!ill) cnt_model = cnt_model + 4'd1;
    check_val({tag, " back to fetch"}, {27'd0, state}, 32'd0);
    check_val({tag, " illegal_op"}, {31'd0, illegal_op}, {31'd0, ill});
    check_val({tag, " instret"}, {28'd0, instret}, {28'd0, cnt_model});
    $display("instr %-10s op=%b f3=%b states=%0d illegal=%0b instret=%0d",
             tag, op, f3, n, ill, instret);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cnt_model = 4'd0;
    opcode    = 7'd0;
    funct3    = 3'd0;
    rst_n     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_val("reset state", {27'd0, state}, 32'd0);
    check_val("reset illegal_op", {31'd0, illegal_op}, 32'd0);
    check_val("reset instret", {28'd0, instret}, 32'd0);
    check_val("reset instr_done", {31'd0, instr_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // First FETCH spans the rest of this cycle; state moves to DECODE at the edge.

    do_instr("ADD",   7'b0110011, 3'b000, 5'd6,  5'd7,  5'd0, 4, 1'b0);
    do_instr("LW",    7'b0000011, 3'b010, 5'd2,  5'd3,  5'd4, 5, 1'b0);
    do_instr("SH",    7'b0100011, 3'b001, 5'd2,  5'd14, 5'd0, 4, 1'b0);
    do_instr("SB",    7'b0100011, 3'b000, 5'd2,  5'd13, 5'd0, 4, 1'b0);
    do_instr("SW",    7'b0100011, 3'b010, 5'd2,  5'd5,  5'd0, 4, 1'b0);
    do_instr("BEQ",   7'b1100011, 3'b000, 5'd8,  5'd0,  5'd0, 3, 1'b0);
    do_instr("BNE",   7'b1100011, 3'b001, 5'd15, 5'd0,  5'd0, 3, 1'b0);
    do_instr("BLT",   7'b1100011, 3'b100, 5'd16, 5'd0,  5'd0, 3, 1'b0);
    do_instr("BGE",   7'b1100011, 3'b101, 5'd17, 5'd0,  5'd0, 3, 1'b0);
    do_instr("BLTU",  7'b1100011, 3'b110, 5'd18, 5'd0,  5'd0, 3, 1'b0);
    do_instr("BGEU",  7'b1100011, 3'b111, 5'd19, 5'd0,  5'd0, 3, 1'b0);
    do_instr("BR010", 7'b1100011, 3'b010, 5'd0,  5'd0,  5'd0, 2, 1'b1);
    do_instr("OP00",  7'b0000000, 3'b000, 5'd0,  5'd0,  5'd0, 2, 1'b1);
    do_instr("OP7F",  7'b1111111, 3'b000, 5'd0,  5'd0,  5'd0, 2, 1'b1);
    do_instr("ST011", 7'b0100011, 3'b011, 5'd0,  5'd0,  5'd0, 2, 1'b1);
    do_instr("LD110", 7'b0000011, 3'b110, 5'd0,  5'd0,  5'd0, 2, 1'b1);
    do_instr("JAL",   7'b1101111, 3'b000, 5'd11, 5'd0,  5'd0, 3, 1'b0);
    do_instr("JALR",  7'b1100111, 3'b000, 5'd12, 5'd0,  5'd0, 3, 1'b0);
    do_instr("LUI",   7'b0110111, 3'b000, 5'd21, 5'd0,  5'd0, 3, 1'b0);
    do_instr("AUIPC", 7'b0010111, 3'b000, 5'd20, 5'd0,  5'd0, 3, 1'b0);
    do_instr("ADDI",  7'b0010011, 3'b000, 5'd9,  5'd10, 5'd0, 4, 1'b0);

    // Asynchronous reset in the middle of a load (state 3).
    opcode = 7'b0000011;
    funct3 = 3'b010;
    repeat (3) @(posedge clk);
    #1;
    check_val("pre-reset state", {27'd0, state}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async reset state", {27'd0, state}, 32'd0);
    check_val("async reset instret", {28'd0, instret}, 32'd0);
    cnt_model = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("instr %-10s async reset during MEMRD instret=%0d", "RESET", instret);

    // 17 retirements on a 4-bit counter wrap to 1.
    for (int k = 0; k < 17; k++) begin
      case (k % 4)
        0: do_instr("W-JAL",   7'b1101111, 3'b000, 5'd11, 5'd0, 5'd0, 3, 1'b0);
        1: do_instr("W-JALR",  7'b1100111, 3'b000, 5'd12, 5'd0, 5'd0, 3, 1'b0);
        2: do_instr("W-LUI",   7'b0110111, 3'b000, 5'd21, 5'd0, 5'd0, 3, 1'b0);
        default: do_instr("W-AUIPC", 7'b0010111, 3'b000, 5'd20, 5'd0, 5'd0, 3, 1'b0);
      endcase
    end
    check_val("instret wrap", {28'd0, instret}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
